// File: rtl/fpu_stream_xactor_if.sv
// Signal bundle between fpu_stream_xactor and its environment: input stream,
// FPU issue/return port and output stream.
interface fpu_stream_xactor_if #(
   parameter int DATA_WIDTH = 32,
   parameter int FLAG_WIDTH = 8,
   parameter int OUT_DEPTH  = 8
);
   logic                             in_valid;
   logic                             in_ready;
   logic [2*DATA_WIDTH+4:0]          in_data;
   logic                             in_eom;
   logic                             fpu_start;
   logic [DATA_WIDTH-1:0]            fpu_opa;
   logic [DATA_WIDTH-1:0]            fpu_opb;
   logic [1:0]                       fpu_rmode;
   logic [2:0]                       fpu_op;
   logic [DATA_WIDTH-1:0]            fpu_result;
   logic [FLAG_WIDTH-1:0]            fpu_flags;
   logic                             out_valid;
   logic                             out_ready;
   logic [FLAG_WIDTH+DATA_WIDTH-1:0] out_data;
   logic                             out_eom;
   logic [$clog2(OUT_DEPTH+1)-1:0]   inflight;
   logic                             done;

   modport master (
      output in_valid, in_data, in_eom, out_ready, fpu_result, fpu_flags,
      input  in_ready, fpu_start, fpu_opa, fpu_opb, fpu_rmode, fpu_op,
             out_valid, out_data, out_eom, inflight, done
   );

   modport slave (
      input  in_valid, in_data, in_eom, out_ready, fpu_result, fpu_flags,
      output in_ready, fpu_start, fpu_opa, fpu_opb, fpu_rmode, fpu_op,
             out_valid, out_data, out_eom, inflight, done
   );
endinterface

// File: rtl/fpu_stream_xactor.sv
// Stream transactor: buffers packed operands, issues them to a fixed-latency FPU
// under output credit, and returns {flags, result} in issue order with EOM/drain.
module fpu_stream_xactor #(
   parameter int DATA_WIDTH  = 32,
   parameter int FLAG_WIDTH  = 8,
   parameter int FPU_LATENCY = 4,
   parameter int IN_DEPTH    = 8,
   parameter int OUT_DEPTH   = 8
) (
   input logic                clk,
   input logic                reset,
   fpu_stream_xactor_if.slave bus
);

   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam int CNT_W  = $clog2(OUT_DEPTH + 1);
   localparam int IN_W   = 2*DATA_WIDTH + 6;
   localparam int OUT_W  = FLAG_WIDTH + DATA_WIDTH + 1;

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DRAIN = 1'b1} state_t;

   state_t                  state_r;
   state_t                  state_nxt_s;
   logic [IN_W-1:0]         in_mem_r [IN_DEPTH];
   logic [IN_AW:0]          in_wptr_r;
   logic [IN_AW:0]          in_rptr_r;
   logic [IN_AW:0]          in_wptr_nxt_s;
   logic [IN_AW:0]          in_rptr_nxt_s;
   logic                    in_empty_s;
   logic                    in_full_s;
   logic                    in_full_nxt_s;
   logic                    in_push_s;
   logic                    in_ready_r;
   logic [IN_W-1:0]         in_head_s;
   logic                    issue_s;
   logic [CNT_W-1:0]        inflight_r;
   logic [CNT_W:0]          credit_s;
   logic [FPU_LATENCY-1:0]  pipe_v_r;
   logic [FPU_LATENCY-1:0]  pipe_e_r;
   logic                    cap_s;
   logic                    cap_eom_s;
   logic [OUT_W-1:0]        out_mem_r [OUT_DEPTH];
   logic [OUT_AW:0]         out_wptr_r;
   logic [OUT_AW:0]         out_rptr_r;
   logic [OUT_AW:0]         out_cnt_s;
   logic                    out_valid_s;
   logic                    out_full_s;
   logic                    out_pop_s;
   logic [OUT_W-1:0]        out_head_s;
   logic                    fpu_start_r;
   logic [DATA_WIDTH-1:0]   fpu_opa_r;
   logic [DATA_WIDTH-1:0]   fpu_opb_r;
   logic [1:0]              fpu_rmode_r;
   logic [2:0]              fpu_op_r;
   logic                    done_r;

   // FIFO status, credit check and next-pointer computation
   always_comb begin
      in_empty_s    = (in_wptr_r == in_rptr_r);
      in_full_s     = (in_wptr_r[IN_AW] != in_rptr_r[IN_AW]) &&
                      (in_wptr_r[IN_AW-1:0] == in_rptr_r[IN_AW-1:0]);
      in_push_s     = bus.in_valid && in_ready_r;
      in_head_s     = in_mem_r[in_rptr_r[IN_AW-1:0]];
      out_cnt_s     = out_wptr_r - out_rptr_r;
      out_valid_s   = (out_wptr_r != out_rptr_r);
      out_full_s    = (out_cnt_s == (OUT_AW+1)'(OUT_DEPTH));
      out_head_s    = out_mem_r[out_rptr_r[OUT_AW-1:0]];
      out_pop_s     = out_valid_s && bus.out_ready;
      // Credit counts only registered occupancy; a pop this cycle frees nothing yet.
      credit_s      = {1'b0, inflight_r} + (CNT_W+1)'(out_cnt_s);
      issue_s       = !in_empty_s && (credit_s < (CNT_W+1)'(OUT_DEPTH));
      in_wptr_nxt_s = in_wptr_r + (IN_AW+1)'(in_push_s);
      in_rptr_nxt_s = in_rptr_r + (IN_AW+1)'(issue_s);
      in_full_nxt_s = (in_wptr_nxt_s[IN_AW] != in_rptr_nxt_s[IN_AW]) &&
                      (in_wptr_nxt_s[IN_AW-1:0] == in_rptr_nxt_s[IN_AW-1:0]);
      cap_s         = pipe_v_r[FPU_LATENCY-1];
      cap_eom_s     = pipe_e_r[FPU_LATENCY-1];
   end

   // Run/drain next-state decision
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (in_push_s && bus.in_eom) begin
               state_nxt_s = ST_DRAIN;
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_DRAIN: begin
            if (out_pop_s && out_head_s[OUT_W-1]) begin
               state_nxt_s = ST_RUN;
            end else begin
               state_nxt_s = ST_DRAIN;
            end
         end
         default: state_nxt_s = ST_RUN;
      endcase
   end

   // State register; in_ready and done are registered from next-cycle values
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= ST_RUN;
         in_ready_r <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         in_ready_r <= (state_nxt_s == ST_RUN) && !in_full_nxt_s;
         done_r     <= (state_r == ST_DRAIN) && (state_nxt_s == ST_RUN);
      end
   end

   // Input FIFO pointers
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_wptr_r <= {(IN_AW+1){1'b0}};
         in_rptr_r <= {(IN_AW+1){1'b0}};
      end else begin
         in_wptr_r <= in_wptr_nxt_s;
         in_rptr_r <= in_rptr_nxt_s;
      end
   end

   // Input FIFO storage: {eom, op, rmode, opa, opb}
   always_ff @(posedge clk) begin
      if (in_push_s) begin
         in_mem_r[in_wptr_r[IN_AW-1:0]] <= {bus.in_eom, bus.in_data};
      end
   end

   // Issue registers; operands hold their last value between issues
   always_ff @(posedge clk) begin
      if (!reset) begin
         fpu_start_r <= 1'b0;
         fpu_opa_r   <= {DATA_WIDTH{1'b0}};
         fpu_opb_r   <= {DATA_WIDTH{1'b0}};
         fpu_rmode_r <= 2'b00;
         fpu_op_r    <= 3'b000;
      end else begin
         fpu_start_r <= issue_s;
         if (issue_s) begin
            fpu_op_r    <= in_head_s[2*DATA_WIDTH+4 -: 3];
            fpu_rmode_r <= in_head_s[2*DATA_WIDTH+1 -: 2];
            fpu_opa_r   <= in_head_s[2*DATA_WIDTH-1 -: DATA_WIDTH];
            fpu_opb_r   <= in_head_s[DATA_WIDTH-1:0];
         end
      end
   end

   // Issue pipe tracking FPU latency, and the in-flight counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         pipe_v_r   <= {FPU_LATENCY{1'b0}};
         pipe_e_r   <= {FPU_LATENCY{1'b0}};
         inflight_r <= {CNT_W{1'b0}};
      end else begin
         for (int i = FPU_LATENCY-1; i > 0; i--) begin
            pipe_v_r[i] <= pipe_v_r[i-1];
            pipe_e_r[i] <= pipe_e_r[i-1];
         end
         pipe_v_r[0] <= issue_s;
         pipe_e_r[0] <= issue_s && in_head_s[IN_W-1];
         case ({issue_s, cap_s})
            2'b10:   inflight_r <= inflight_r + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   inflight_r <= inflight_r - {{(CNT_W-1){1'b0}}, 1'b1};
            default: inflight_r <= inflight_r;
         endcase
      end
   end

   // Output FIFO pointers
   always_ff @(posedge clk) begin
      if (!reset) begin
         out_wptr_r <= {(OUT_AW+1){1'b0}};
         out_rptr_r <= {(OUT_AW+1){1'b0}};
      end else begin
         out_wptr_r <= out_wptr_r + (OUT_AW+1)'(cap_s);
         out_rptr_r <= out_rptr_r + (OUT_AW+1)'(out_pop_s);
      end
   end

   // Output FIFO storage: {eom, flags, result} captured as the pipe exits
   always_ff @(posedge clk) begin
      if (cap_s) begin
         out_mem_r[out_wptr_r[OUT_AW-1:0]] <= {cap_eom_s, bus.fpu_flags, bus.fpu_result};
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.fpu_start = fpu_start_r;
   assign bus.fpu_opa   = fpu_opa_r;
   assign bus.fpu_opb   = fpu_opb_r;
   assign bus.fpu_rmode = fpu_rmode_r;
   assign bus.fpu_op    = fpu_op_r;
   assign bus.out_valid = out_valid_s;
   // Head is masked so stale storage never shows after reset
   assign bus.out_data  = out_valid_s ? out_head_s[OUT_W-2:0] : {(OUT_W-1){1'b0}};
   assign bus.out_eom   = out_valid_s && out_head_s[OUT_W-1];
   assign bus.inflight  = inflight_r;
   assign bus.done      = done_r;

   fpu_stream_xactor_chk u_chk (
      .clk      (clk),
      .reset    (reset),
      .in_push  (in_push_s),
      .in_full  (in_full_s),
      .out_push (cap_s),
      .out_full (out_full_s)
   );

endmodule

// FIFO overflow checker for fpu_stream_xactor
module fpu_stream_xactor_chk (
   input logic clk,
   input logic reset,
   input logic in_push,
   input logic in_full,
   input logic out_push,
   input logic out_full
);
   a_in_no_overflow:  assert property (@(posedge clk) disable iff (!reset) !(in_push && in_full));
   a_out_no_overflow: assert property (@(posedge clk) disable iff (!reset) !(out_push && out_full));
endmodule
